// File: rtl/move_validator.sv
// Board-state owner for the tic-tac-toe datapath: accepts move requests, checks lock/range/turn/occupancy,
// then commits the move or rejects it with a cause code, one request per three cycles.
module move_validator #(
   parameter int CELLS        = 9,
   parameter int IDX_W        = 4,
   parameter int CNT_W        = 4,
   parameter bit FIRST_PLAYER = 1'b0,
   parameter bit ENFORCE_TURN = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 game_over,
   input  logic                 move_valid,
   output logic                 move_ready,
   input  logic                 move_player,
   input  logic [IDX_W-1:0]     move_cell,
   output logic                 resp_valid,
   output logic                 resp_legal,
   output logic [2:0]           resp_cause,
   output logic [2*CELLS-1:0]   board,
   output logic [CNT_W-1:0]     move_count,
   output logic                 board_full,
   output logic                 turn
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   localparam logic [2:0] CAUSE_OK     = 3'd0;
   localparam logic [2:0] CAUSE_LOCKED = 3'd1;
   localparam logic [2:0] CAUSE_RANGE  = 3'd2;
   localparam logic [2:0] CAUSE_TURN   = 3'd3;
   localparam logic [2:0] CAUSE_OCC    = 3'd4;

   state_t               state_reg, state_next;
   logic [2*CELLS-1:0]   board_reg, board_next;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic                 turn_reg, turn_next;
   logic [IDX_W-1:0]     cell_reg, cell_next;
   logic                 player_reg, player_next;
   logic                 legal_reg, legal_next;
   logic [2:0]           cause_reg, cause_next;
   logic [2:0]           eval_cause;

   logic [CELLS-1:0]     cell_hit;
   logic [CELLS-1:0]     cell_occ;

   // Per-cell decode of the latched target; any non-00 code (including 11) counts as occupied.
   generate
      for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
         assign cell_hit[gi] = (cell_reg == IDX_W'(gi));
         assign cell_occ[gi] = |board_reg[2*gi +: 2];
      end
   endgenerate

   assign board_full = (count_reg == CNT_W'(CELLS));
   assign move_ready = (state_reg == IDLE);
   assign resp_valid = (state_reg == RESP) && !clear;
   assign resp_legal = legal_reg;
   assign resp_cause = cause_reg;
   assign board      = board_reg;
   assign move_count = count_reg;
   assign turn       = turn_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         board_reg  <= '0;
         count_reg  <= '0;
         turn_reg   <= FIRST_PLAYER;
         cell_reg   <= '0;
         player_reg <= 1'b0;
         legal_reg  <= 1'b0;
         cause_reg  <= CAUSE_OK;
      end else begin
         state_reg  <= state_next;
         board_reg  <= board_next;
         count_reg  <= count_next;
         turn_reg   <= turn_next;
         cell_reg   <= cell_next;
         player_reg <= player_next;
         legal_reg  <= legal_next;
         cause_reg  <= cause_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      board_next  = board_reg;
      count_next  = count_reg;
      turn_next   = turn_reg;
      cell_next   = cell_reg;
      player_next = player_reg;
      legal_next  = legal_reg;
      cause_next  = cause_reg;

      // First matching rule wins.
      if (game_over || board_full)
         eval_cause = CAUSE_LOCKED;
      else if (32'(cell_reg) >= CELLS)
         eval_cause = CAUSE_RANGE;
      else if (ENFORCE_TURN && (player_reg != turn_reg))
         eval_cause = CAUSE_TURN;
      else if (|(cell_hit & cell_occ))
         eval_cause = CAUSE_OCC;
      else
         eval_cause = CAUSE_OK;

      case (state_reg)
         IDLE: begin
            if (move_valid) begin
               cell_next   = move_cell;
               player_next = move_player;
               state_next  = EVAL;
            end
         end
         EVAL: begin
            state_next = RESP;
            cause_next = eval_cause;
            legal_next = (eval_cause == CAUSE_OK);
            if (eval_cause == CAUSE_OK) begin
               count_next = count_reg + CNT_W'(1);
               turn_next  = ~player_reg;
               for (int i = 0; i < CELLS; i++) begin
                  if (cell_hit[i])
                     board_next[2*i +: 2] = player_reg ? 2'b10 : 2'b01;
               end
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // New-game request overrides everything, including a handshake in the same cycle.
      if (clear) begin
         state_next  = IDLE;
         board_next  = '0;
         count_next  = '0;
         turn_next   = FIRST_PLAYER;
         cell_next   = '0;
         player_next = 1'b0;
         legal_next  = 1'b0;
         cause_next  = CAUSE_OK;
      end
   end

endmodule

// File: tb/tb_move_validator.sv
// Scoreboard bench for move_validator: three instances (3x3 turn-enforced, 3x3 free-turn, 4x4)
// share one stimulus stream and are checked against a small reference model.
module tb_move_validator;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       clear = 1'b0;
   logic       game_over = 1'b0;
   logic       move_valid = 1'b0;
   logic       move_player = 1'b0;
   logic [3:0] move_cell = 4'd0;

   logic ready_a, rv_a, legal_a, full_a, turn_a;
   logic [2:0] cause_a;
   logic [17:0] board_a;
   logic [3:0] count_a;
   logic ready_b, rv_b, legal_b, full_b, turn_b;
   logic [2:0] cause_b;
   logic [17:0] board_b;
   logic [3:0] count_b;
   logic ready_c, rv_c, legal_c, full_c, turn_c;
   logic [2:0] cause_c;
   logic [31:0] board_c;
   logic [4:0] count_c;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]      legal;
      logic [2:0][2:0] cause;
   } resp_t;
   resp_t sb[$];

   int          cells_p[3] = '{9, 9, 16};
   bit          enf_p[3]   = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_board[3];
   int          m_count[3];
   logic        m_turn[3];

   always #5 clock = ~clock;

   move_validator #(.CELLS(9), .IDX_W(4), .CNT_W(4), .FIRST_PLAYER(1'b0), .ENFORCE_TURN(1'b1)) dut_a (
      .clock(clock), .reset(reset), .clear(clear), .game_over(game_over),
      .move_valid(move_valid), .move_ready(ready_a), .move_player(move_player), .move_cell(move_cell),
      .resp_valid(rv_a), .resp_legal(legal_a), .resp_cause(cause_a), .board(board_a),
      .move_count(count_a), .board_full(full_a), .turn(turn_a));

   move_validator #(.CELLS(9), .IDX_W(4), .CNT_W(4), .FIRST_PLAYER(1'b0), .ENFORCE_TURN(1'b0)) dut_b (
      .clock(clock), .reset(reset), .clear(clear), .game_over(game_over),
      .move_valid(move_valid), .move_ready(ready_b), .move_player(move_player), .move_cell(move_cell),
      .resp_valid(rv_b), .resp_legal(legal_b), .resp_cause(cause_b), .board(board_b),
      .move_count(count_b), .board_full(full_b), .turn(turn_b));

   move_validator #(.CELLS(16), .IDX_W(4), .CNT_W(5), .FIRST_PLAYER(1'b0), .ENFORCE_TURN(1'b1)) dut_c (
      .clock(clock), .reset(reset), .clear(clear), .game_over(game_over),
      .move_valid(move_valid), .move_ready(ready_c), .move_player(move_player), .move_cell(move_cell),
      .resp_valid(rv_c), .resp_legal(legal_c), .resp_cause(cause_c), .board(board_c),
      .move_count(count_c), .board_full(full_c), .turn(turn_c));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] obs_board(input int k);
      case (k)
         0:       return 64'(board_a);
         1:       return 64'(board_b);
         default: return 64'(board_c);
      endcase
   endfunction

   function automatic logic [63:0] obs_count(input int k);
      case (k)
         0:       return 64'(count_a);
         1:       return 64'(count_b);
         default: return 64'(count_c);
      endcase
   endfunction

   // Packs {ready, resp_valid, legal, full, turn, cause} for one instance.
   function automatic logic [7:0] obs_flags(input int k);
      case (k)
         0:       return {ready_a, rv_a, legal_a, full_a, turn_a, cause_a};
         1:       return {ready_b, rv_b, legal_b, full_b, turn_b, cause_b};
         default: return {ready_c, rv_c, legal_c, full_c, turn_c, cause_c};
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_board[k] = '0;
         m_count[k] = 0;
         m_turn[k]  = 1'b0;
      end
   endtask

   task automatic model_eval(input logic p, input logic [3:0] c, input logic go);
      resp_t e;
      logic [2:0] cs;
      for (int k = 0; k < 3; k++) begin
         if (go || m_count[k] == cells_p[k])             cs = 3'd1;
         else if (int'(c) >= cells_p[k])                  cs = 3'd2;
         else if (enf_p[k] && p != m_turn[k])             cs = 3'd3;
         else if (m_board[k][2*int'(c) +: 2] != 2'b00)    cs = 3'd4;
         else                                             cs = 3'd0;
         e.cause[k] = cs;
         e.legal[k] = (cs == 3'd0);
         if (cs == 3'd0) begin
            m_board[k][2*int'(c) +: 2] = p ? 2'b10 : 2'b01;
            m_count[k]++;
            m_turn[k] = ~p;
         end
      end
      sb.push_back(e);
   endtask

   task automatic check_state(input string tag, input int k);
      logic [7:0] f;
      f = obs_flags(k);
      check($sformatf("%s_board%0d", tag, k), obs_board(k), 64'(m_board[k]));
      check($sformatf("%s_count%0d", tag, k), obs_count(k), 64'(m_count[k]));
      check($sformatf("%s_turn%0d", tag, k), 64'(f[3]), 64'(m_turn[k]));
      check($sformatf("%s_full%0d", tag, k), 64'(f[4]), 64'(m_count[k] == cells_p[k]));
   endtask

   task automatic check_reset(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_flags%0d", tag, k), 64'(obs_flags(k)), 64'h80);
         check_state(tag, k);
      end
   endtask

   task automatic do_move(input logic p, input logic [3:0] c, input logic go);
      int    lat;
      bit    got;
      resp_t e;
      logic [7:0] f;
      @(negedge clock);
      move_valid = 1'b1; move_player = p; move_cell = c; game_over = go;
      @(posedge clock);
      model_eval(p, c, go);
      #1 move_valid = 1'b0;
      lat = 0; got = 1'b0;
      repeat (4) begin
         @(negedge clock);
         lat++;
         if (rv_a) begin
            got = 1'b1;
            break;
         end
      end
      game_over = 1'b0;
      check("latency", got ? 64'(lat) : 64'd99, 64'd2);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         f = obs_flags(k);
         check($sformatf("rv%0d", k), 64'(f[6]), 64'd1);
         check($sformatf("ready%0d", k), 64'(f[7]), 64'd0);
         check($sformatf("legal%0d", k), 64'(f[5]), 64'(e.legal[k]));
         check($sformatf("cause%0d", k), 64'(f[2:0]), 64'(e.cause[k]));
         check_state("move", k);
      end
      $display("txn p=%0d cell=%0d go=%0d exp_cause=%0d/%0d/%0d dut_cause=%0d/%0d/%0d count=%0d/%0d/%0d",
               p, c, go, e.cause[0], e.cause[1], e.cause[2], cause_a, cause_b, cause_c,
               count_a, count_b, count_c);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      model_reset();
      repeat (2) @(negedge clock);
      check_reset("por");
      reset = 1'b1;

      do_move(1'b0, 4'd4, 1'b0);   // legal everywhere
      do_move(1'b1, 4'd4, 1'b0);   // occupied
      do_move(1'b0, 4'd0, 1'b0);   // wrong turn, legal without turn check
      do_move(1'b0, 4'd9, 1'b0);   // out of range on 3x3
      do_move(1'b0, 4'd9, 1'b1);   // lock outranks range

      for (int c = 0; c < 9; c++)
         if (c != 4) do_move(m_turn[0], 4'(c), 1'b0);
      check("full_a", 64'(full_a), 64'd1);
      check("count_a", 64'(count_a), 64'd9);
      do_move(m_turn[0], 4'd0, 1'b0);   // full board is locked

      @(negedge clock); clear = 1'b1;
      @(negedge clock); clear = 1'b0;
      model_reset();
      check_reset("clear");

      do_move(1'b0, 4'd2, 1'b0);
      do_move(1'b1, 4'd15, 1'b0);   // range on 3x3, legal on 4x4

      // Asynchronous reset while the request is in EVAL.
      @(negedge clock);
      move_valid = 1'b1; move_player = 1'b1; move_cell = 4'd3;
      @(posedge clock);
      #1 move_valid = 1'b0;
      #2 reset = 1'b0;
      #1 model_reset();
      check_reset("arst");
      @(negedge clock); reset = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (rv_a | rv_b | rv_c) seen = 1'b1;
      end
      check("arst_norv", 64'(seen), 64'd0);

      // Clear asserted during RESP suppresses the strobe and drops the request.
      do_move(1'b0, 4'd1, 1'b0);
      @(negedge clock);
      move_valid = 1'b1; move_player = 1'b1; move_cell = 4'd5;
      @(posedge clock);
      #1 move_valid = 1'b0;
      @(posedge clock);
      #1 clear = 1'b1;
      #1 check("clr_rv", 64'(rv_a | rv_b | rv_c), 64'd0);
      @(posedge clock);
      #1 clear = 1'b0;
      model_reset();
      check_reset("clrresp");
      seen = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (rv_a | rv_b | rv_c) seen = 1'b1;
      end
      check("clr_norv", 64'(seen), 64'd0);

      do_move(1'b0, 4'd8, 1'b0);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_validator.md
Name: move_validator

Overview:
- Sequential, parametrised successor to the combinational occupancy check used by the tic-tac-toe datapath.
- Owns the board state: one 2-bit code per cell, 00 empty, 01 player, 10 computer.
- Accepts move requests over a valid/ready handshake, checks each one against lock, range, turn and occupancy rules, then either commits it or rejects it with a cause code.
- Sits between the player/computer move sources and the winner-detection and display logic, and is the single source of truth for the board.

Parameters:
CELLS, 9, number of board cells (9 for 3x3, 16 for 4x4, ...); legal range 2..64
IDX_W, 4, width of move_cell; must satisfy 2^IDX_W >= CELLS
CNT_W, 4, width of move_count; must satisfy 2^CNT_W > CELLS
FIRST_PLAYER, 0, side to move after reset/clear (0 player, 1 computer)
ENFORCE_TURN, 1, 1 = wrong-side moves are rejected; 0 = turn check disabled

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous new-game request, active-high
game_over  in  1  from winner detector; locks the board
move_valid  in  1  move request present
move_ready  out  1  validator can accept a request
move_player  in  1  requesting side: 0 player (code 01), 1 computer (code 10)
move_cell  in  IDX_W  target cell index, 0-based
resp_valid  out  1  one-cycle result strobe
resp_legal  out  1  1 = move committed; qualified by resp_valid
resp_cause  out  3  0 ok, 1 locked, 2 out of range, 3 wrong turn, 4 occupied
board  out  2*CELLS  cell i occupies bits [2i+1:2i]
move_count  out  CNT_W  number of committed moves
board_full  out  1  move_count == CELLS
turn  out  1  side expected to move next

Behaviour:
- Reset (reset low, asynchronous): board=0, move_count=0, turn=FIRST_PLAYER, state IDLE, move_ready=1, resp_valid=0, resp_legal=0, resp_cause=0.
- FSM states: IDLE, EVAL, RESP.
  - IDLE: move_ready=1. On move_valid&&move_ready at clock edge T, latch move_cell and move_player, go to EVAL.
  - EVAL: move_ready=0. Evaluate the latched request against the current board. Result registers, any board write, count and turn update take effect at the edge ending EVAL. Go to RESP.
  - RESP: move_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Latency: resp_valid is high in the cycle beginning at edge T+2. The updated board, move_count and turn are visible in that same cycle.
- Throughput: one request per 3 cycles.
- Cause priority, first match wins:
  1. locked: game_over=1 during EVAL, or board_full.
  2. out of range: latched cell >= CELLS.
  3. wrong turn: ENFORCE_TURN=1 and latched player != turn.
  4. occupied: target cell != 00.
  5. otherwise legal, cause 0.
- Legal move commit:
  - cell <= 01 if player 0, 10 if player 1.
  - move_count += 1.
  - turn <= ~latched player (when ENFORCE_TURN=0 as well).
- Illegal move: board, count and turn are unchanged; resp_legal=0.
- board_full is combinational from move_count; move_count never exceeds CELLS.
- Code 11 is never written to a cell. A cell holding 11 is treated as occupied.
- clear: synchronous, highest priority in every state.
  - Same register values as reset, state back to IDLE.
  - A request in EVAL/RESP is dropped with no resp_valid.
  - If clear coincides with a handshake, the request is discarded.
- game_over is sampled only in EVAL. A change in IDLE or RESP has no effect on a request already evaluated.
- move_valid held high through RESP is not consumed again until the next IDLE cycle (move_ready gates acceptance).
- resp_legal and resp_cause hold their last values between strobes. They are meaningful only when resp_valid=1.

Test Plan:
- After reset, player requests cell 4 -> resp_valid at T+2, legal=1, cause 0; board[9:8]=01, move_count=1, turn=1.
- After that, computer requests cell 4 -> legal=0, cause 4 (occupied); board, count and turn unchanged.
- Player requests cell 0 while turn=1 -> cause 3. Repeat with ENFORCE_TURN=0 -> legal=1 and turn flips to 1.
- move_cell=9 (CELLS=9) -> cause 2. Same request with game_over=1 -> cause 1 (lock outranks range).
- Nine alternating legal moves -> board_full=1, move_count=9. A tenth request -> cause 1. Assert clear -> board=0, count=0, turn=FIRST_PLAYER.
- Drop reset low during EVAL -> outputs zero immediately and no resp_valid. Assert clear during RESP -> strobe suppressed. CELLS=16, IDX_W=4: cell 15 legal, board width 32.
